decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DEPTH, default 2: output buffer entries; power of two, >=2.
REQ-002 Parameter PC_W, default 32: program-counter width.
REQ-003 Port clk  input  1: single clock; all state on rising edge.
REQ-004 Port rst  input  1: synchronous, active-high reset.
REQ-005 Port in_valid  input  1: fetch presents instruction.
REQ-006 Port in_ready  output  1: stage accepts instruction this cycle.
REQ-007 Port in_inst  input  32: RV32 instruction word.
REQ-008 Port in_pc  input  PC_W: instruction address.
REQ-009 Port flush  input  1: discard all buffered and incoming instructions.
REQ-010 Port out_valid  output  1: head entry valid.
REQ-011 Port out_ready  input  1: consumer takes head entry.
REQ-012 Port out_pc  output  PC_W: head PC.
REQ-013 Port out_rd, out_rs1, out_rs2  output  5 each: register indices from inst[11:7], [19:15], [24:20].
REQ-014 Port out_imm  output  32: sign-extended immediate.
REQ-015 Port out_ctrl  output  ctrl_t: regWrite, memRead, memWrite, branch, jump, jalr, aluSrcImm, funct3, aluOp[15:0], immType[2:0].
REQ-016 Port out_illegal  output  1: head instruction is illegal.
REQ-017 Port out_count  output  $clog2(DEPTH)+1: occupancy.

Function
REQ-018 Push when in_valid && in_ready && !flush; pop when out_valid && out_ready && !flush.
REQ-019 in_ready SHALL equal (count < DEPTH), registered-state only, with no combinational path from out_ready.
REQ-020 Instruction pushed at edge N SHALL be visible at head no earlier than cycle N+1; latency 1 cycle when empty.
REQ-021 Entries SHALL leave in push order; head/tail pointers wrap modulo DEPTH.
REQ-022 Simultaneous push and pop when not full SHALL keep count unchanged; when full, in_ready=0, so only pop occurs.
REQ-023 flush SHALL take priority: next cycle count=0, out_valid=0, same-cycle input dropped, pointers reset to 0.
REQ-024 Decoded control for opcodes OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC SHALL match the team's single-cycle decoder encoding (same aluOp/immType codes).
REQ-025 Immediate SHALL be generated per immType (I, S, B, U, J), sign-extended from inst[31]; IMM_NONE yields 0.
REQ-026 Unknown opcode, undefined R-type funct7/funct3 pair, or SLLI/SRLI/SRAI with funct7 not 0x00/0x20 SHALL set illegal=1 and ctrl to all-zero with aluOp=ALU_NOP.
REQ-027 Held outputs SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-028 During rst: count=0, pointers=0, out_valid=0, in_ready=0.
REQ-029 Cycle after rst deasserts: in_ready=1; out_* data outputs read 0 while empty.
REQ-030 rst mid-operation SHALL discard all entries; rst overrides flush and push.

Configuration
REQ-031 Macro RV32M_EN defined: funct7=0x01 OP instructions decode to ALU_MUL..ALU_REMU, illegal=0.
REQ-032 RV32M_EN undefined: funct7=0x01 OP instructions SHALL set illegal=1, regWrite=0, aluOp=ALU_NOP.

Structure
REQ-033 Package decode_pkg SHALL hold ALU_* and IMM_* constants, opcode constants, and ctrl_t struct.
REQ-034 Combinational decode plus immediate generation SHALL live in sub-module decode_logic; decode_stage holds buffer, pointers, count.

Verification
REQ-035 0x002081B3 (ADD x3,x1,x2) into empty stage -> next cycle out_valid=1, rd=3, rs1=1, rs2=2, aluOp=ALU_ADD, regWrite=1, illegal=0.
REQ-036 0xFFF00093 (ADDI x1,x0,-1) -> out_imm=0xFFFFFFFF, immType=IMM_I, aluSrcImm=1.
REQ-037 out_ready=0, push DEPTH+1 instructions PCs 0x0,0x4,... -> in_ready=0 after DEPTH pushes, count=DEPTH; release -> PCs emerge in order, extra pushed after space frees.
REQ-038 0x022081B3 (MUL) -> aluOp=ALU_MUL, illegal=0 with RV32M_EN; illegal=1, regWrite=0 without.
REQ-039 Full buffer, flush with in_valid=1 -> next cycle count=0, out_valid=0, flushed input never appears.
REQ-040 rst asserted with 1 entry buffered and push pending -> next cycle count=0, out_valid=0; 0x0000007F -> illegal=1.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode constants, control bundle and immediate generator for the decode stage.
// Optional RV32M support is enabled by defining RV32M_EN.
package decode_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [15:0] ALU_NOP    = 16'd0;
    localparam logic [15:0] ALU_ADD    = 16'd1;
    localparam logic [15:0] ALU_SUB    = 16'd2;
    localparam logic [15:0] ALU_SLL    = 16'd3;
    localparam logic [15:0] ALU_SLT    = 16'd4;
    localparam logic [15:0] ALU_SLTU   = 16'd5;
    localparam logic [15:0] ALU_XOR    = 16'd6;
    localparam logic [15:0] ALU_SRL    = 16'd7;
    localparam logic [15:0] ALU_SRA    = 16'd8;
    localparam logic [15:0] ALU_OR     = 16'd9;
    localparam logic [15:0] ALU_AND    = 16'd10;
    localparam logic [15:0] ALU_LUI    = 16'd11;
    localparam logic [15:0] ALU_MUL    = 16'd12;
    localparam logic [15:0] ALU_MULH   = 16'd13;
    localparam logic [15:0] ALU_MULHSU = 16'd14;
    localparam logic [15:0] ALU_MULHU  = 16'd15;
    localparam logic [15:0] ALU_DIV    = 16'd16;
    localparam logic [15:0] ALU_DIVU   = 16'd17;
    localparam logic [15:0] ALU_REM    = 16'd18;
    localparam logic [15:0] ALU_REMU   = 16'd19;

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        jalr;
        logic        alu_src_imm;
        logic [2:0]  funct3;
        logic [15:0] alu_op;
        logic [2:0]  imm_type;
    } ctrl_t;

    function automatic logic [31:0] gen_imm(input logic [31:0] inst, input logic [2:0] imm_type);
        logic [31:0] imm;
        case (imm_type)
            IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm = {inst[31:12], 12'h000};
            IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = 32'h0000_0000;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_logic.sv
// Purely combinational RV32I instruction decoder plus immediate generation.
// Defining RV32M_EN adds the funct7=0x01 multiply/divide group to OP decode.
module decode_logic
    import decode_pkg::*;
(
    input  logic [31:0] inst,
    output ctrl_t       ctrl,
    output logic [31:0] imm,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    always_comb begin
        ctrl        = '0;
        illegal     = 1'b0;
        ctrl.funct3 = funct3;
        case (opcode)
            OPC_OP: begin
                ctrl.reg_write = 1'b1;
                case ({funct7, funct3})
                    {7'h00, 3'b000}: ctrl.alu_op = ALU_ADD;
                    {7'h20, 3'b000}: ctrl.alu_op = ALU_SUB;
                    {7'h00, 3'b001}: ctrl.alu_op = ALU_SLL;
                    {7'h00, 3'b010}: ctrl.alu_op = ALU_SLT;
                    {7'h00, 3'b011}: ctrl.alu_op = ALU_SLTU;
                    {7'h00, 3'b100}: ctrl.alu_op = ALU_XOR;
                    {7'h00, 3'b101}: ctrl.alu_op = ALU_SRL;
                    {7'h20, 3'b101}: ctrl.alu_op = ALU_SRA;
                    {7'h00, 3'b110}: ctrl.alu_op = ALU_OR;
                    {7'h00, 3'b111}: ctrl.alu_op = ALU_AND;
`ifdef RV32M_EN
                    {7'h01, 3'b000}: ctrl.alu_op = ALU_MUL;
                    {7'h01, 3'b001}: ctrl.alu_op = ALU_MULH;
                    {7'h01, 3'b010}: ctrl.alu_op = ALU_MULHSU;
                    {7'h01, 3'b011}: ctrl.alu_op = ALU_MULHU;
                    {7'h01, 3'b100}: ctrl.alu_op = ALU_DIV;
                    {7'h01, 3'b101}: ctrl.alu_op = ALU_DIVU;
                    {7'h01, 3'b110}: ctrl.alu_op = ALU_REM;
                    {7'h01, 3'b111}: ctrl.alu_op = ALU_REMU;
`endif
                    default: illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                ctrl.imm_type    = IMM_I;
                case (funct3)
                    3'b000: ctrl.alu_op = ALU_ADD;
                    3'b010: ctrl.alu_op = ALU_SLT;
                    3'b011: ctrl.alu_op = ALU_SLTU;
                    3'b100: ctrl.alu_op = ALU_XOR;
                    3'b110: ctrl.alu_op = ALU_OR;
                    3'b111: ctrl.alu_op = ALU_AND;
                    3'b001: begin
                        if (funct7 == 7'h00) ctrl.alu_op = ALU_SLL;
                        else                 illegal = 1'b1;
                    end
                    default: begin
                        if (funct7 == 7'h00)      ctrl.alu_op = ALU_SRL;
                        else if (funct7 == 7'h20) ctrl.alu_op = ALU_SRA;
                        else                      illegal = 1'b1;
                    end
                endcase
            end
            OPC_LOAD: begin
                ctrl.reg_write   = 1'b1;
                ctrl.mem_read    = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                ctrl.imm_type    = IMM_I;
                ctrl.alu_op      = ALU_ADD;
            end
            OPC_STORE: begin
                ctrl.mem_write   = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                ctrl.imm_type    = IMM_S;
                ctrl.alu_op      = ALU_ADD;
            end
            OPC_BRANCH: begin
                ctrl.branch   = 1'b1;
                ctrl.imm_type = IMM_B;
                ctrl.alu_op   = ALU_SUB;
            end
            OPC_JAL: begin
                ctrl.reg_write = 1'b1;
                ctrl.jump      = 1'b1;
                ctrl.imm_type  = IMM_J;
                ctrl.alu_op    = ALU_ADD;
            end
            OPC_JALR: begin
                ctrl.reg_write   = 1'b1;
                ctrl.jump        = 1'b1;
                ctrl.jalr        = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                ctrl.imm_type    = IMM_I;
                ctrl.alu_op      = ALU_ADD;
            end
            OPC_LUI: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                ctrl.imm_type    = IMM_U;
                ctrl.alu_op      = ALU_LUI;
            end
            OPC_AUIPC: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                ctrl.imm_type    = IMM_U;
                ctrl.alu_op      = ALU_ADD;
            end
            default: illegal = 1'b1;
        endcase
        // Illegal instructions must not leak partial control into the pipeline.
        if (illegal) begin
            ctrl = '0;
        end
    end

    assign imm = gen_imm(inst, ctrl.imm_type);

endmodule

// File: rtl/decode_stage_logic.sv
// Single-bit pass-through cell kept alongside the decode stage; not instantiated by decode_stage.
module decode_stage_logic_unused (
    input  logic a,
    output logic y
);
    assign y = a;
endmodule

// File: rtl/decode_stage.sv
// Decode stage: DEPTH-entry in-order buffer of fetched instructions, decoded at the head.
// Define RV32M_EN to accept the multiply/divide extension in decode_logic.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PC_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_inst,
    input  logic [PC_W-1:0]            in_pc,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            out_pc,
    output logic [4:0]                 out_rd,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [31:0]                out_imm,
    output ctrl_t                      out_ctrl,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH):0]     out_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]     inst_q [DEPTH];
    logic [31:0]     inst_d [DEPTH];
    logic [PC_W-1:0] pc_q   [DEPTH];
    logic [PC_W-1:0] pc_d   [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic        push;
    logic        pop;
    logic [31:0] head_inst;
    ctrl_t       dec_ctrl;
    logic [31:0] dec_imm;
    logic        dec_illegal;

    // Ready and valid depend only on registered state (and reset), never on out_ready.
    assign in_ready  = !rst && (count_q < CNT_W'(DEPTH));
    assign out_valid = !rst && (count_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        inst_d   = inst_q;
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                inst_d[wr_ptr_q] = in_inst;
                pc_d[wr_ptr_q]   = in_pc;
                wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        inst_q <= inst_d;
        pc_q   <= pc_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_inst = inst_q[rd_ptr_q];

    decode_logic u_decode_logic (
        .inst    (head_inst),
        .ctrl    (dec_ctrl),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    // Stale slots are masked so an empty stage presents all-zero data.
    assign out_pc      = out_valid ? pc_q[rd_ptr_q] : '0;
    assign out_rd      = out_valid ? head_inst[11:7] : 5'd0;
    assign out_rs1     = out_valid ? head_inst[19:15] : 5'd0;
    assign out_rs2     = out_valid ? head_inst[24:20] : 5'd0;
    assign out_imm     = out_valid ? dec_imm : 32'h0;
    assign out_ctrl    = out_valid ? dec_ctrl : '0;
    assign out_illegal = out_valid && dec_illegal;
    assign out_count   = count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: buffering, flush/reset and decode vectors.
module tb_decode_stage;
    import decode_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned PC_W  = 32;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [31:0] INST_ADD = 32'h002081B3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [PC_W-1:0]  in_pc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [PC_W-1:0]  out_pc;
    logic [4:0]       out_rd;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [31:0]      out_imm;
    ctrl_t            out_ctrl;
    logic             out_illegal;
    logic [CNT_W-1:0] out_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    decode_stage #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_imm     (out_imm),
        .out_ctrl    (out_ctrl),
        .out_illegal (out_illegal),
        .out_count   (out_count)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic push_one(input logic [31:0] inst, input logic [PC_W-1:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain_one();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_inst = INST_ADD; in_pc = 32'h10;
        repeat (2) @(negedge clk);
        vectors++;
        if ({in_ready, out_valid, out_count} !== {1'b0, 1'b0, CNT_W'(0)}) begin
            miscompares++;
            $display("FAIL reset_hold got rdy=%0b vld=%0b cnt=%0d want 0/0/0",
                     in_ready, out_valid, out_count);
        end
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({in_ready, out_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_release got rdy=%0b vld=%0b want 1/0", in_ready, out_valid);
        end
        vectors++;
        if ({out_pc, out_rd, out_rs1, out_rs2, out_imm, out_ctrl, out_illegal} !== '0) begin
            miscompares++;
            $display("FAIL reset_data got pc=%h imm=%h ctrl=%h ill=%0b want all 0",
                     out_pc, out_imm, out_ctrl, out_illegal);
        end
    endtask

    task automatic test_add();
        push_one(INST_ADD, 32'h100);
        vectors++;
        if ({out_valid, out_rd, out_rs1, out_rs2} !== {1'b1, 5'd3, 5'd1, 5'd2}) begin
            miscompares++;
            $display("FAIL add_regs got v=%0b rd=%0d rs1=%0d rs2=%0d want 1/3/1/2",
                     out_valid, out_rd, out_rs1, out_rs2);
        end
        vectors++;
        if ({out_ctrl.alu_op, out_ctrl.reg_write, out_illegal, out_pc} !==
            {ALU_ADD, 1'b1, 1'b0, 32'h100}) begin
            miscompares++;
            $display("FAIL add_ctrl got alu=%0d rw=%0b ill=%0b pc=%h want %0d/1/0/100",
                     out_ctrl.alu_op, out_ctrl.reg_write, out_illegal, out_pc, ALU_ADD);
        end
        drain_one();
        vectors++;
        if ({out_valid, out_count} !== {1'b0, CNT_W'(0)}) begin
            miscompares++;
            $display("FAIL add_pop got v=%0b cnt=%0d want 0/0", out_valid, out_count);
        end
    endtask

    task automatic test_immediates();
        push_one(32'hFFF00093, 32'h0);  // addi x1,x0,-1
        vectors++;
        if ({out_imm, out_ctrl.imm_type, out_ctrl.alu_src_imm, out_rd} !==
            {32'hFFFFFFFF, IMM_I, 1'b1, 5'd1}) begin
            miscompares++;
            $display("FAIL addi_imm got imm=%h type=%0d src=%0b rd=%0d want ffffffff/%0d/1/1",
                     out_imm, out_ctrl.imm_type, out_ctrl.alu_src_imm, out_rd, IMM_I);
        end
        drain_one();
        push_one(32'hFE20AE23, 32'h0);  // sw x2,-4(x1)
        vectors++;
        if ({out_imm, out_ctrl.imm_type, out_ctrl.mem_write, out_ctrl.reg_write} !==
            {32'hFFFFFFFC, IMM_S, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL sw_imm got imm=%h type=%0d mw=%0b rw=%0b want fffffffc/%0d/1/0",
                     out_imm, out_ctrl.imm_type, out_ctrl.mem_write, out_ctrl.reg_write, IMM_S);
        end
        drain_one();
        push_one(32'h123452B7, 32'h0);  // lui x5,0x12345
        vectors++;
        if ({out_imm, out_ctrl.alu_op, out_rd} !== {32'h12345000, ALU_LUI, 5'd5}) begin
            miscompares++;
            $display("FAIL lui_imm got imm=%h alu=%0d rd=%0d want 12345000/%0d/5",
                     out_imm, out_ctrl.alu_op, out_rd, ALU_LUI);
        end
        drain_one();
        push_one(32'h00000863, 32'h0);  // beq x0,x0,+16
        vectors++;
        if ({out_imm, out_ctrl.branch, out_ctrl.imm_type} !== {32'h10, 1'b1, IMM_B}) begin
            miscompares++;
            $display("FAIL beq_imm got imm=%h br=%0b type=%0d want 10/1/%0d",
                     out_imm, out_ctrl.branch, out_ctrl.imm_type, IMM_B);
        end
        drain_one();
        push_one(32'hFFDFF0EF, 32'h0);  // jal x1,-4
        vectors++;
        if ({out_imm, out_ctrl.jump, out_ctrl.reg_write, out_ctrl.imm_type} !==
            {32'hFFFFFFFC, 1'b1, 1'b1, IMM_J}) begin
            miscompares++;
            $display("FAIL jal_imm got imm=%h j=%0b rw=%0b type=%0d want fffffffc/1/1/%0d",
                     out_imm, out_ctrl.jump, out_ctrl.reg_write, out_ctrl.imm_type, IMM_J);
        end
        drain_one();
    endtask

    task automatic test_illegal();
        logic [31:0] bad [3];
        bad[0] = 32'h0000007F;  // unknown opcode
        bad[1] = 32'h402091B3;  // OP funct7=0x20 funct3=001
        bad[2] = 32'h2010D093;  // SRAI with funct7=0x10
        for (int i = 0; i < 3; i++) begin
            push_one(bad[i], 32'h0);
            vectors++;
            if ({out_valid, out_illegal, out_ctrl} !== {1'b1, 1'b1, ctrl_t'('0)}) begin
                miscompares++;
                $display("FAIL illegal_%0d got v=%0b ill=%0b ctrl=%h want 1/1/0",
                         i, out_valid, out_illegal, out_ctrl);
            end
            drain_one();
        end
        push_one(32'h4010D093, 32'h0);  // srai x1,x1,1
        vectors++;
        if ({out_illegal, out_ctrl.alu_op, out_imm} !== {1'b0, ALU_SRA, 32'h401}) begin
            miscompares++;
            $display("FAIL srai got ill=%0b alu=%0d imm=%h want 0/%0d/401",
                     out_illegal, out_ctrl.alu_op, out_imm, ALU_SRA);
        end
        drain_one();
    endtask

    task automatic test_mul();
        push_one(32'h022081B3, 32'h0);
        vectors++;
`ifdef RV32M_EN
        if ({out_illegal, out_ctrl.alu_op, out_ctrl.reg_write} !== {1'b0, ALU_MUL, 1'b1}) begin
            miscompares++;
            $display("FAIL mul got ill=%0b alu=%0d rw=%0b want 0/%0d/1",
                     out_illegal, out_ctrl.alu_op, out_ctrl.reg_write, ALU_MUL);
        end
`else
        if ({out_illegal, out_ctrl.alu_op, out_ctrl.reg_write} !== {1'b1, ALU_NOP, 1'b0}) begin
            miscompares++;
            $display("FAIL mul got ill=%0b alu=%0d rw=%0b want 1/%0d/0",
                     out_illegal, out_ctrl.alu_op, out_ctrl.reg_write, ALU_NOP);
        end
`endif
        drain_one();
    endtask

    task automatic test_full_order();
        logic [PC_W-1:0] got [$];
        bit fi;
        bit fo;
        for (int i = 0; i < DEPTH; i++) push_one(INST_ADD, PC_W'(4 * i));
        vectors++;
        if ({in_ready, out_count} !== {1'b0, CNT_W'(DEPTH)}) begin
            miscompares++;
            $display("FAIL full got rdy=%0b cnt=%0d want 0/%0d", in_ready, out_count, DEPTH);
        end
        in_valid = 1'b1; in_inst = INST_ADD; in_pc = PC_W'(4 * DEPTH);
        @(negedge clk);
        vectors++;
        if ({out_pc, out_count, out_valid} !== {PC_W'(0), CNT_W'(DEPTH), 1'b1}) begin
            miscompares++;
            $display("FAIL hold got pc=%h cnt=%0d v=%0b want 0/%0d/1", out_pc, out_count,
                     out_valid, DEPTH);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 4 * DEPTH + 8 && got.size() < DEPTH + 1; c++) begin
            #1;
            fo = out_valid && out_ready;
            fi = in_valid && in_ready;
            if (fo) got.push_back(out_pc);
            @(negedge clk);
            if (fi) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        vectors++;
        if (got.size() != DEPTH + 1) begin
            miscompares++;
            $display("FAIL order_count got %0d pops want %0d", got.size(), DEPTH + 1);
        end
        for (int i = 0; i < got.size(); i++) begin
            vectors++;
            if (got[i] !== PC_W'(4 * i)) begin
                miscompares++;
                $display("FAIL order_%0d got pc=%h want %h", i, got[i], 4 * i);
            end
        end
    endtask

    task automatic test_back_to_back();
        push_one(INST_ADD, 32'h200);
        in_valid = 1'b1; in_inst = INST_ADD; in_pc = 32'h204; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        vectors++;
        if ({out_count, out_pc} !== {CNT_W'(1), 32'h204}) begin
            miscompares++;
            $display("FAIL b2b got cnt=%0d pc=%h want 1/204", out_count, out_pc);
        end
        drain_one();
    endtask

    task automatic test_flush();
        for (int i = 0; i < DEPTH; i++) push_one(INST_ADD, PC_W'(32'h300 + 4 * i));
        in_valid = 1'b1; in_pc = 32'h3F0; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        vectors++;
        if ({out_count, out_valid, in_ready} !== {CNT_W'(0), 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL flush got cnt=%0d v=%0b rdy=%0b want 0/0/1", out_count, out_valid,
                     in_ready);
        end
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_drop got v=%0b want 0", out_valid);
        end
        push_one(INST_ADD, 32'h340);
        vectors++;
        if ({out_count, out_pc} !== {CNT_W'(1), 32'h340}) begin
            miscompares++;
            $display("FAIL flush_refill got cnt=%0d pc=%h want 1/340", out_count, out_pc);
        end
        drain_one();
    endtask

    task automatic test_rst_mid();
        push_one(INST_ADD, 32'h500);
        rst = 1'b1; in_valid = 1'b1; in_pc = 32'h504; flush = 1'b1;
        @(negedge clk);
        vectors++;
        if ({out_count, out_valid, in_ready} !== {CNT_W'(0), 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_mid got cnt=%0d v=%0b rdy=%0b want 0/0/0", out_count, out_valid,
                     in_ready);
        end
        rst = 1'b0; in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        vectors++;
        if ({out_count, out_valid, in_ready} !== {CNT_W'(0), 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL rst_after got cnt=%0d v=%0b rdy=%0b want 0/0/1", out_count,
                     out_valid, in_ready);
        end
        push_one(32'h0000007F, 32'h600);
        vectors++;
        if ({out_valid, out_illegal, out_pc} !== {1'b1, 1'b1, 32'h600}) begin
            miscompares++;
            $display("FAIL rst_illegal got v=%0b ill=%0b pc=%h want 1/1/600", out_valid,
                     out_illegal, out_pc);
        end
        drain_one();
    endtask

    initial begin
        test_reset();
        test_add();
        test_immediates();
        test_illegal();
        test_mul();
        test_full_order();
        test_back_to_back();
        test_flush();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
